// File: rtl/mmio_uart_pkg.sv
// Shared register map, STATUS bit positions and TX state encoding for the MMIO UART transmitter.
package mmio_uart_pkg;

   localparam logic [1:0] OFS_DATA   = 2'd0;
   localparam logic [1:0] OFS_STATUS = 2'd1;
   localparam logic [1:0] OFS_DIV    = 2'd2;

   localparam int ST_BUSY      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_OVERFLOW  = 3;
   localparam int ST_COUNT_LSB = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   // A divisor of 0 or 1 both mean one clock per bit.
   function automatic logic [15:0] effDiv(input logic [15:0] div);
      return (div < 16'd2) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/mmio_fifo.sv
// DEPTH x 8 circular FIFO; a push into a full FIFO is accepted only when a pop happens on the same edge.
module mmio_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [7:0]                 wdata_i,
   output logic [7:0]                 rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       drop_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [AW:0]   count_q, count_d;
   logic          doPush, doPop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rdPtr_q];

   assign doPop  = pop_i && !empty_o;
   assign doPush = push_i && (!full_o || doPop);
   assign drop_o = push_i && !doPush;

   always_comb begin
      wrPtr_d = doPush ? wrPtr_q + PTR_ONE : wrPtr_q;
      rdPtr_d = doPop  ? rdPtr_q + PTR_ONE : rdPtr_q;
      case ({doPush, doPop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: DATA/STATUS/DIV register window, byte FIFO and 8N1 serialiser.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1 frames).
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int          DEPTH     = 8,
   parameter logic [15:0] DIV_RESET = 16'd434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] mem_addr,
   input  logic        mem_wr,
   input  logic [31:0] mem_writedata,
   output logic [31:0] mem_readdata,
   output logic        hit,
   output logic        txd,
   output logic        irq_empty
);

   localparam int CW = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
   localparam logic PAR_FEATURE = 1'b1;
`else
   localparam logic PAR_FEATURE = 1'b0;
`endif

   tx_state_t      state_q, state_d;
   logic [15:0]    cnt_q, cnt_d;
   logic [2:0]     bitIdx_q, bitIdx_d;
   logic [7:0]     txByte_q, txByte_d;
   logic [15:0]    div_q, div_d;
   logic           overflow_q, overflow_d;

   logic [31:0]    offset;
   logic [1:0]     regSel;
   logic           wrEn, pushReq, busy, tick;
   logic [15:0]    bitPeriod;
   logic           fifoPop, fifoFull, fifoEmpty, fifoDrop;
   logic [7:0]     fifoRdata;
   logic [CW-1:0]  fifoCount;
   logic [31:0]    statusWord;
   logic           unusedWdata;

   assign unusedWdata = ^mem_writedata[31:16];

   // Subtracting the base keeps the decode correct for any word-aligned BASE_ADDR.
   assign offset  = mem_addr - BASE_ADDR;
   assign hit     = (offset < 32'd12) && (offset[1:0] == 2'b00);
   assign regSel  = offset[3:2];
   assign wrEn    = mem_wr && enable && hit;
   assign pushReq = wrEn && (regSel == OFS_DATA);

   mmio_fifo #(.DEPTH(DEPTH)) uFifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .push_i  (pushReq),
      .pop_i   (fifoPop),
      .wdata_i (mem_writedata[7:0]),
      .rdata_o (fifoRdata),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .drop_o  (fifoDrop),
      .count_o (fifoCount)
   );

   always_comb begin
      div_d      = div_q;
      overflow_d = overflow_q;
      if (wrEn && (regSel == OFS_DIV)) begin
         div_d = mem_writedata[15:0];
      end
      if (wrEn && (regSel == OFS_STATUS)) begin
         overflow_d = 1'b0;
      end else if (fifoDrop) begin
         overflow_d = 1'b1;
      end
   end

   always_comb begin
      statusWord                          = '0;
      statusWord[ST_BUSY]                 = busy;
      statusWord[ST_FULL]                 = fifoFull;
      statusWord[ST_EMPTY]                = fifoEmpty;
      statusWord[ST_OVERFLOW]             = overflow_q;
      statusWord[ST_COUNT_LSB +: CW]      = fifoCount;
      mem_readdata = '0;
      if (hit) begin
         case (regSel)
            OFS_STATUS: mem_readdata = statusWord;
            OFS_DIV:    mem_readdata = {15'd0, PAR_FEATURE, div_q};
            default:    mem_readdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bitIdx_q   <= '0;
         txByte_q   <= '0;
         div_q      <= DIV_RESET;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bitIdx_q   <= bitIdx_d;
         txByte_q   <= txByte_d;
         div_q      <= div_d;
         overflow_q <= overflow_d;
      end
   end

   assign tick      = (cnt_q == 16'd0);
   assign bitPeriod = effDiv(div_q) - 16'd1;

   // The baud counter reloads from the live DIV on every bit boundary, so DIV writes land on the next bit.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitIdx_d = bitIdx_q;
      txByte_d = txByte_q;
      fifoPop  = 1'b0;
      if (state_q != IDLE) begin
         cnt_d = tick ? bitPeriod : cnt_q - 16'd1;
      end
      case (state_q)
         IDLE: begin
            if (!fifoEmpty) begin
               state_d  = START;
               fifoPop  = 1'b1;
               txByte_d = fifoRdata;
               cnt_d    = bitPeriod;
            end
         end
         START: begin
            if (tick) begin
               state_d  = DATA;
               bitIdx_d = 3'd0;
            end
         end
         DATA: begin
            if (tick) begin
               bitIdx_d = bitIdx_q + 3'd1;
               if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
         PARITY: begin
            if (tick) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               if (!fifoEmpty) begin
                  state_d  = START;
                  fifoPop  = 1'b1;
                  txByte_d = fifoRdata;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      txd = 1'b1;
      case (state_q)
         START:  txd = 1'b0;
         DATA:   txd = txByte_q[bitIdx_q];
`ifdef UART_TX_PARITY_EN
         PARITY: txd = ^txByte_q;
`endif
         default: txd = 1'b1;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign irq_empty = fifoEmpty && !busy;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx; expectations follow UART_TX_PARITY_EN when defined.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef UART_TX_PARITY_EN
   localparam bit PARITY_ON = 1'b1;
`else
   localparam bit PARITY_ON = 1'b0;
`endif
   localparam logic [31:0] DIV_FLAG = PARITY_ON ? 32'h0001_0000 : 32'h0;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        hit;
   logic        txd;
   logic        irq_empty;

   int          compareCount = 0;
   int          mismatchCount = 0;
   logic        expBits[$];
   logic [31:0] rd;

   mmio_uart_tx dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .mem_addr      (mem_addr),
      .mem_wr        (mem_wr),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .hit           (hit),
      .txd           (txd),
      .irq_empty     (irq_empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         mismatchCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      checkOutput(tag, {31'd0, observed}, {31'd0, expected});
   endtask

   // Drive one bus cycle; returns 1 ns after the edge that commits it.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic wr, input logic en);
      mem_addr      = addr;
      mem_writedata = data;
      mem_wr        = wr;
      enable        = en;
      @(posedge clk);
      #1;
      mem_wr = 1'b0;
      enable = 1'b1;
   endtask

   task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
      mem_wr   = 1'b0;
      mem_addr = addr;
      #1;
      data = mem_readdata;
   endtask

   task automatic pushFrame(input logic [7:0] b);
      expBits.push_back(1'b0);
      for (int i = 0; i < 8; i++) expBits.push_back(b[i]);
      if (PARITY_ON) expBits.push_back(^b);
      expBits.push_back(1'b1);
   endtask

   // Check txd every clock against the expected bit sequence, each bit lasting div clocks.
   task automatic checkLine(input string tag, input int div);
      for (int i = 0; i < expBits.size(); i++) begin
         for (int c = 0; c < div; c++) begin
            checkBit(tag, txd, expBits[i]);
            checkBit({tag, "_irq"}, irq_empty, 1'b0);
            @(posedge clk);
            #1;
         end
      end
      expBits.delete();
   endtask

   task automatic doReset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset         = 1'b0;
      enable        = 1'b1;
      mem_wr        = 1'b0;
      mem_addr      = '0;
      mem_writedata = '0;

      $display("[TB] reset state");
      #12;
      checkBit("rst_txd", txd, 1'b1);
      checkBit("rst_irq", irq_empty, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      readReg(BASE + 32'd4, rd);
      checkOutput("status_rst", rd, 32'h0000_0004);
      readReg(BASE + 32'd8, rd);
      checkOutput("div_rst", rd, DIV_FLAG | 32'd434);
      readReg(BASE, rd);
      checkOutput("data_rd", rd, 32'h0);
      checkBit("hit_base", hit, 1'b1);
      readReg(BASE + 32'd20, rd);
      checkOutput("miss_rd", rd, 32'h0);
      checkBit("hit_miss", hit, 1'b0);
      @(posedge clk);
      #1;

      $display("[TB] single frame 0x55, DIV=4");
      applyStimulus(BASE + 32'd8, 32'd4, 1'b1, 1'b1);
      readReg(BASE + 32'd8, rd);
      checkOutput("div_wr", rd, DIV_FLAG | 32'd4);
      @(posedge clk);
      #1;
      applyStimulus(BASE, 32'h55, 1'b1, 1'b1);
      checkBit("n_txd", txd, 1'b1);
      checkBit("n_irq", irq_empty, 1'b0);
      readReg(BASE + 32'd4, rd);
      checkOutput("status_queued", rd, 32'h0000_0100);
      @(posedge clk);
      #1;
      readReg(BASE + 32'd4, rd);
      checkOutput("status_busy", rd, 32'h0000_0005);
      pushFrame(8'h55);
      checkLine("frame55", 4);
      checkBit("idle_irq", irq_empty, 1'b1);
      checkBit("idle_txd", txd, 1'b1);

      $display("[TB] overflow, DIV=100");
      applyStimulus(BASE + 32'd8, 32'd100, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) applyStimulus(BASE, 32'h10 + 32'(i), 1'b1, 1'b1);
      readReg(BASE + 32'd4, rd);
      checkOutput("status_full", rd, 32'h0000_0803);
      applyStimulus(BASE, 32'h99, 1'b1, 1'b1);
      readReg(BASE + 32'd4, rd);
      checkOutput("status_ovf", rd, 32'h0000_080B);
      applyStimulus(BASE + 32'd4, 32'h0, 1'b1, 1'b1);
      readReg(BASE + 32'd4, rd);
      checkOutput("status_ovf_clr", rd, 32'h0000_0803);
      checkBit("ovf_start_txd", txd, 1'b0);
      doReset();
      readReg(BASE + 32'd4, rd);
      checkOutput("status_after_rst", rd, 32'h0000_0004);

      $display("[TB] back-to-back frames, DIV=2");
      applyStimulus(BASE + 32'd8, 32'd2, 1'b1, 1'b1);
      applyStimulus(BASE, 32'hA3, 1'b1, 1'b1);
      applyStimulus(BASE, 32'h0F, 1'b1, 1'b1);
      pushFrame(8'hA3);
      pushFrame(8'h0F);
      checkLine("b2b", 2);
      checkBit("b2b_idle_irq", irq_empty, 1'b1);

      $display("[TB] gated and missed writes");
      applyStimulus(BASE, 32'h77, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      readReg(BASE + 32'd4, rd);
      checkOutput("gated_status", rd, 32'h0000_0004);
      checkBit("gated_txd", txd, 1'b1);
      mem_addr = BASE + 32'd20;
      #1;
      checkBit("miss_hit", hit, 1'b0);
      applyStimulus(BASE + 32'd20, 32'h33, 1'b1, 1'b1);
      readReg(BASE + 32'd9, rd);
      checkBit("unaligned_hit", hit, 1'b0);
      @(posedge clk);
      #1;
      applyStimulus(BASE + 32'd9, 32'd7, 1'b1, 1'b1);
      readReg(BASE + 32'd8, rd);
      checkOutput("div_kept", rd, DIV_FLAG | 32'd2);
      readReg(BASE + 32'd4, rd);
      checkOutput("miss_status", rd, 32'h0000_0004);
      @(posedge clk);
      #1;

      $display("[TB] reset mid-frame");
      applyStimulus(BASE + 32'd8, 32'd4, 1'b1, 1'b1);
      applyStimulus(BASE, 32'h55, 1'b1, 1'b1);
      applyStimulus(BASE, 32'hAA, 1'b1, 1'b1);
      repeat (17) @(posedge clk);
      #1;
      checkBit("bit3_txd", txd, 1'b0);
      reset = 1'b0;
      #1;
      checkBit("async_txd", txd, 1'b1);
      checkBit("async_irq", irq_empty, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      readReg(BASE + 32'd4, rd);
      checkOutput("status_mid_rst", rd, 32'h0000_0004);
      readReg(BASE + 32'd8, rd);
      checkOutput("div_mid_rst", rd, DIV_FLAG | 32'd434);
      for (int c = 0; c < 60; c++) begin
         checkBit("quiet_txd", txd, 1'b1);
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
